w0rm_mem_copy_initiator: RTL and testbench



---
 rtl/w0rm_mem_copy_initiator_pkg.sv | 30 +++
 rtl/w0rm_mem_timeout.sv | 52 +++++
 rtl/w0rm_mem_copy_initiator.sv | 211 +++++++++++++++++++++
 tb/tb_w0rm_mem_copy_initiator.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_mem_copy_initiator_pkg.sv
// ---------------------------------------------------------------------------
// w0rm_mem_copy_initiator_pkg
// Shared definitions for the W0RM memory-copy initiator:
//   - copyState_e   : FSM state encoding used by the top-level copy engine
//   - TAG_DIR_*     : value of the direction bit carried in the user tag
//   - strideBytes() : byte stride between consecutive words on the bus
// No ports; imported by the initiator top and its timeout sub-module.
// ---------------------------------------------------------------------------
package w0rm_mem_copy_initiator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_WAIT = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERROR   = 3'd6
   } copyState_e;

   // Direction bit of the request tag; it sits in the MSB of the user field.
   localparam logic TAG_DIR_READ  = 1'b0;
   localparam logic TAG_DIR_WRITE = 1'b1;

   // Consecutive words are this many byte addresses apart.
   function automatic int unsigned strideBytes(input int unsigned dataWidth);
      return dataWidth / 8;
   endfunction

endpackage

// File: rtl/w0rm_mem_timeout.sv
// ---------------------------------------------------------------------------
// w0rm_mem_timeout
// Counts cycles spent waiting for a single bus response and flags expiry.
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   clear_i    restart the count (asserted the cycle before a wait begins)
//   enable_i   high while the initiator is waiting for a response
//   expired_o  high in the last allowed wait cycle (TIMEOUT-th) of a wait
// ---------------------------------------------------------------------------
import w0rm_mem_copy_initiator_pkg::*;

module w0rm_mem_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   // The count holds the number of wait cycles already completed, so it
   // reaches TIMEOUT-1 during the TIMEOUT-th cycle of waiting.
   localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam int unsigned CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturate at LAST so a long stall can never wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Wait-cycle counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/w0rm_mem_copy_initiator.sv
// ---------------------------------------------------------------------------
// w0rm_mem_copy_initiator
// DMA-style copy engine on the W0RM memory-request bus: copies count_i words
// from src_addr_i to dst_addr_i, one read then one write per word, tagging
// each request through the user sideband and checking the echoed tag.
// Ports:
//   mem_clk, cpu_reset            clock, asynchronous active-low reset
//   start_i, src/dst_addr_i,
//   count_i                       copy command, accepted only when idle
//   busy_o, done_o, error_o       status (done pulses, error is sticky)
//   mem_m_*_o                     request channel (registered, zero when idle)
//   mem_m_valid_i/data_i/user_i   response channel from the responder
// ---------------------------------------------------------------------------
import w0rm_mem_copy_initiator_pkg::*;

module w0rm_mem_copy_initiator #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned USER_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 16,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                   mem_clk,
   input  logic                   cpu_reset,
   input  logic                   start_i,
   input  logic [ADDR_WIDTH-1:0]  src_addr_i,
   input  logic [ADDR_WIDTH-1:0]  dst_addr_i,
   input  logic [COUNT_WIDTH-1:0] count_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o,
   output logic                   mem_m_valid_o,
   output logic                   mem_m_read_o,
   output logic                   mem_m_write_o,
   output logic [ADDR_WIDTH-1:0]  mem_m_addr_o,
   output logic [DATA_WIDTH-1:0]  mem_m_data_o,
   output logic [USER_WIDTH-1:0]  mem_m_user_o,
   input  logic                   mem_m_valid_i,
   input  logic [DATA_WIDTH-1:0]  mem_m_data_i,
   input  logic [USER_WIDTH-1:0]  mem_m_user_i
);

   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(strideBytes(DATA_WIDTH));

   // Tag layout: direction in the MSB, word index in the low bits, zeros between.
   function automatic logic [USER_WIDTH-1:0] makeTag(input logic dirWrite,
                                                     input logic [COUNT_WIDTH-1:0] idx);
      logic [USER_WIDTH-1:0] tag;
      tag                  = '0;
      tag[COUNT_WIDTH-1:0] = idx;
      tag[USER_WIDTH-1]    = dirWrite;
      return tag;
   endfunction

   copyState_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  srcPtr_q, srcPtr_d, dstPtr_q, dstPtr_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d, idx_q, idx_d, idxInc;
   logic [DATA_WIDTH-1:0]  word_q, word_d;
   logic                   error_q, error_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic                   mValid_q, mValid_d, mRead_q, mRead_d, mWrite_q, mWrite_d;
   logic [ADDR_WIDTH-1:0]  mAddr_q, mAddr_d;
   logic [DATA_WIDTH-1:0]  mData_q, mData_d;
   logic [USER_WIDTH-1:0]  mUser_q, mUser_d;
   logic                   tagOk, expired, waiting, issuing;

   assign idxInc  = idx_q + COUNT_WIDTH'(1);
   assign tagOk   = (mem_m_user_i == makeTag(state_q == ST_WR_WAIT, idx_q));
   assign waiting = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
   // Each request state lasts one cycle and always leads into its wait state,
   // so clearing during the request cycle restarts the count on wait entry.
   assign issuing = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);

   w0rm_mem_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i     (mem_clk),
      .rst_ni    (cpu_reset),
      .clear_i   (issuing),
      .enable_i  (waiting),
      .expired_o (expired)
   );

   // Copy sequencing. A response in the expiry cycle is checked before the
   // timeout, so a late-but-in-time response still wins.
   always_comb begin
      state_d  = state_q;
      srcPtr_d = srcPtr_q;
      dstPtr_d = dstPtr_q;
      count_d  = count_q;
      idx_d    = idx_q;
      word_d   = word_q;
      error_d  = error_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               srcPtr_d = src_addr_i;
               dstPtr_d = dst_addr_i;
               count_d  = count_i;
               idx_d    = '0;
               error_d  = 1'b0;
               state_d  = (count_i == '0) ? ST_DONE : ST_RD_REQ;
            end
         end
         ST_RD_REQ: state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (mem_m_valid_i) begin
               if (tagOk) begin
                  word_d  = mem_m_data_i;
                  state_d = ST_WR_REQ;
               end else begin
                  state_d = ST_ERROR;
               end
            end else if (expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_WR_REQ: state_d = ST_WR_WAIT;
         ST_WR_WAIT: begin
            if (mem_m_valid_i) begin
               if (tagOk) begin
                  idx_d    = idxInc;
                  srcPtr_d = srcPtr_q + STRIDE;
                  dstPtr_d = dstPtr_q + STRIDE;
                  state_d  = (idxInc == count_q) ? ST_DONE : ST_RD_REQ;
               end else begin
                  state_d = ST_ERROR;
               end
            end else if (expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (state_d == ST_ERROR) begin
         error_d = 1'b1;
      end
   end

   // Outputs are registered from the next state, so they line up with the
   // state they describe; bus fields are forced to zero outside requests.
   always_comb begin
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_DONE);
      mRead_d  = (state_d == ST_RD_REQ);
      mWrite_d = (state_d == ST_WR_REQ);
      mValid_d = mRead_d || mWrite_d;
      mAddr_d  = '0;
      mData_d  = '0;
      mUser_d  = '0;
      if (mRead_d) begin
         mAddr_d = srcPtr_d;
         mUser_d = makeTag(TAG_DIR_READ, idx_d);
      end
      if (mWrite_d) begin
         mAddr_d = dstPtr_d;
         mData_d = word_d;
         mUser_d = makeTag(TAG_DIR_WRITE, idx_d);
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge mem_clk or negedge cpu_reset) begin
      if (!cpu_reset) begin
         state_q  <= ST_IDLE;
         srcPtr_q <= '0;
         dstPtr_q <= '0;
         count_q  <= '0;
         idx_q    <= '0;
         word_q   <= '0;
         error_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mValid_q <= 1'b0;
         mRead_q  <= 1'b0;
         mWrite_q <= 1'b0;
         mAddr_q  <= '0;
         mData_q  <= '0;
         mUser_q  <= '0;
      end else begin
         state_q  <= state_d;
         srcPtr_q <= srcPtr_d;
         dstPtr_q <= dstPtr_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         word_q   <= word_d;
         error_q  <= error_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         mValid_q <= mValid_d;
         mRead_q  <= mRead_d;
         mWrite_q <= mWrite_d;
         mAddr_q  <= mAddr_d;
         mData_q  <= mData_d;
         mUser_q  <= mUser_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign mem_m_valid_o = mValid_q;
   assign mem_m_read_o  = mRead_q;
   assign mem_m_write_o = mWrite_q;
   assign mem_m_addr_o  = mAddr_q;
   assign mem_m_data_o  = mData_q;
   assign mem_m_user_o  = mUser_q;

endmodule

// File: tb/tb_w0rm_mem_copy_initiator.sv
// ---------------------------------------------------------------------------
// tb_w0rm_mem_copy_initiator
// Drives copy commands into the initiator, plays a latency-configurable
// memory responder (with dropped-response and bad-tag faults), and compares
// the bus traffic, status timing and destination memory against a
// transaction-level model of the copy.
// ---------------------------------------------------------------------------
module tb_w0rm_mem_copy_initiator;

   localparam int TMO = 15;

   typedef struct {
      bit          isWrite;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] user;
   } req_t;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic [31:0] user;
   } rsp_t;

   logic        mem_clk;
   logic        cpu_reset;
   logic        start_i;
   logic [31:0] src_addr_i, dst_addr_i;
   logic [15:0] count_i;
   logic        busy_o, done_o, error_o;
   logic        mem_m_valid_o, mem_m_read_o, mem_m_write_o;
   logic [31:0] mem_m_addr_o, mem_m_data_o, mem_m_user_o;
   logic        mem_m_valid_i;
   logic [31:0] mem_m_data_i, mem_m_user_i;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   string       curCase = "reset";

   // Responder configuration and state.
   int          rspLat = 1;
   int          rspDropRd = -1;
   bit          rspBadAck = 0;
   int          rdSeen = 0;
   int          wrSeen = 0;
   rsp_t        pendQ[$];
   req_t        expQ[$];
   logic [31:0] busMem   [logic [31:0]];
   logic [31:0] modelMem [logic [31:0]];

   w0rm_mem_copy_initiator #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .USER_WIDTH  (32),
      .COUNT_WIDTH (16),
      .TIMEOUT     (TMO)
   ) dut (
      .mem_clk       (mem_clk),
      .cpu_reset     (cpu_reset),
      .start_i       (start_i),
      .src_addr_i    (src_addr_i),
      .dst_addr_i    (dst_addr_i),
      .count_i       (count_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o),
      .mem_m_valid_o (mem_m_valid_o),
      .mem_m_read_o  (mem_m_read_o),
      .mem_m_write_o (mem_m_write_o),
      .mem_m_addr_o  (mem_m_addr_o),
      .mem_m_data_o  (mem_m_data_o),
      .mem_m_user_o  (mem_m_user_o),
      .mem_m_valid_i (mem_m_valid_i),
      .mem_m_data_i  (mem_m_data_i),
      .mem_m_user_i  (mem_m_user_i)
   );

   initial begin
      mem_clk = 1'b0;
      forever #5 mem_clk = ~mem_clk;
   end

   // Cycle number of the clock period currently in progress.
   always @(posedge mem_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", curCase, tag, observed, expected);
      end
   endtask

   // Initial memory contents: explicit preloads, otherwise an address hash.
   function automatic logic [31:0] initWord(input logic [31:0] addr);
      return (addr * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
   endfunction

   function automatic logic [31:0] modelWord(input logic [31:0] addr);
      if (modelMem.exists(addr)) return modelMem[addr];
      return initWord(addr);
   endfunction

   function automatic logic [31:0] busRead(input logic [31:0] addr);
      if (busMem.exists(addr)) return busMem[addr];
      return initWord(addr);
   endfunction

   function automatic logic [31:0] refTag(input bit isWrite, input int idx);
      return {isWrite, 15'd0, 16'(idx)};
   endfunction

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "/busy"}, busy_o, 1'b0);
      checkOutput({tag, "/done"}, done_o, 1'b0);
      checkOutput({tag, "/valid"}, mem_m_valid_o, 1'b0);
      checkOutput({tag, "/bus"}, |{mem_m_read_o, mem_m_write_o, mem_m_addr_o,
                                   mem_m_data_o, mem_m_user_o}, 1'b0);
   endtask

   // Memory responder: answers each request after rspLat cycles, checks each
   // request against the expected transaction list, and keeps the bus quiet
   // check running every cycle a request is absent.
   initial begin : responder
      rsp_t r;
      req_t e;
      mem_m_valid_i = 1'b0;
      mem_m_data_i  = '0;
      mem_m_user_i  = '0;
      forever begin
         @(posedge mem_clk);
         #1;
         mem_m_valid_i = 1'b0;
         mem_m_data_i  = '0;
         mem_m_user_i  = '0;
         if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
            r = pendQ.pop_front();
            mem_m_valid_i = 1'b1;
            mem_m_data_i  = r.data;
            mem_m_user_i  = r.user;
         end
         @(negedge mem_clk);
         if (mem_m_valid_o) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedReq", {mem_m_read_o, mem_m_write_o, mem_m_addr_o}, 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("reqKind", {mem_m_read_o, mem_m_write_o}, e.isWrite ? 2'b01 : 2'b10);
               checkOutput("reqAddr", mem_m_addr_o, e.addr);
               checkOutput("reqUser", mem_m_user_o, e.user);
               checkOutput("reqData", mem_m_data_o, e.isWrite ? e.data : 32'd0);
            end
            r.due = cyc + rspLat;
            r.user = mem_m_user_o;
            if (mem_m_write_o) begin
               busMem[mem_m_addr_o] = mem_m_data_o;
               wrSeen++;
               r.data = '0;
               if (rspBadAck && wrSeen == 1) r.user = mem_m_user_o ^ 32'd1;
               pendQ.push_back(r);
            end else begin
               rdSeen++;
               r.data = busRead(mem_m_addr_o);
               if (rdSeen - 1 != rspDropRd) pendQ.push_back(r);
            end
         end else begin
            checkOutput("busQuiet", |{mem_m_read_o, mem_m_write_o, mem_m_addr_o,
                                      mem_m_data_o, mem_m_user_o}, 1'b0);
         end
      end
   end

   // Issue one start pulse; startCyc is the cycle in which start_i was high.
   task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] cnt, output int startCyc);
      @(posedge mem_clk);
      #1;
      start_i    = 1'b1;
      src_addr_i = src;
      dst_addr_i = dst;
      count_i    = cnt;
      startCyc   = cyc;
      @(posedge mem_clk);
      #1;
      start_i    = 1'b0;
      src_addr_i = '0;
      dst_addr_i = '0;
      count_i    = '0;
   endtask

   // One complete copy command: builds the expected request list and outcome
   // from the copy rules, runs it, then checks timing, status and memory.
   task automatic runCase(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input int cnt, input int lat, input int dropRd,
                          input bit badAck, input bit glitch);
      int c, evCyc, expCyc;
      bit expErr, gotDone, gotErr;
      req_t e;
      curCase   = name;
      rspLat    = lat;
      rspDropRd = dropRd;
      rspBadAck = badAck;
      rdSeen    = 0;
      wrSeen    = 0;
      expQ.delete();
      for (int i = 0; i < cnt; i++) busMem.delete(dst + 32'(i * 4));
      for (int i = 0; i < cnt; i++) begin
         e.isWrite = 0;
         e.addr    = src + 32'(i * 4);
         e.data    = '0;
         e.user    = refTag(0, i);
         expQ.push_back(e);
         if (i == dropRd) break;
         e.isWrite = 1;
         e.addr    = dst + 32'(i * 4);
         e.data    = modelWord(src + 32'(i * 4));
         e.user    = refTag(1, i);
         expQ.push_back(e);
         if (badAck) break;
      end
      applyStimulus(src, dst, 16'(cnt), c);
      expErr = 0;
      expCyc = c + 1 + cnt * 2 * (lat + 1);
      if (dropRd >= 0 && dropRd < cnt) begin
         expErr = 1;
         expCyc = c + 1 + dropRd * 2 * (lat + 1) + 1 + TMO;
      end else if (badAck && cnt > 0) begin
         expErr = 1;
         expCyc = c + 1 + 2 * (lat + 1);
      end
      gotDone = 0;
      gotErr  = 0;
      evCyc   = -1;
      @(negedge mem_clk);
      checkOutput("errClear", error_o, 1'b0);
      for (int k = 0; k < 400; k++) begin
         if (k > 0) @(negedge mem_clk);
         if (glitch && k == 2) begin
            start_i    = 1'b1;
            src_addr_i = 32'h7777_0000;
            dst_addr_i = 32'h6666_0000;
            count_i    = 16'd9;
         end
         if (glitch && k == 3) start_i = 1'b0;
         if (done_o || error_o) begin
            gotDone = done_o;
            gotErr  = error_o;
            evCyc   = cyc;
            break;
         end
         checkOutput("busyRun", busy_o, 1'b1);
      end
      if (evCyc < 0) checkOutput("waitBudget", 1'b0, 1'b1);
      checkOutput("evDone", gotDone, !expErr);
      checkOutput("evErr", gotErr, expErr);
      checkOutput("evCycle", evCyc, expCyc);
      checkOutput("busyAtEv", busy_o, 1'b1);
      @(negedge mem_clk);
      checkOutput("busyAfter", busy_o, 1'b0);
      checkOutput("donePulse", done_o, 1'b0);
      checkOutput("errSticky", error_o, expErr);
      repeat (lat + 2) @(negedge mem_clk);
      checkOutput("reqLeft", expQ.size(), 0);
      if (!expErr) begin
         for (int i = 0; i < cnt; i++)
            checkOutput("dstWord", busRead(dst + 32'(i * 4)), modelWord(src + 32'(i * 4)));
      end
      start_i = 1'b0;
   endtask

   initial begin : main
      int c;
      logic [31:0] src, dst;
      int cnt, lat;
      req_t e;
      start_i    = 1'b0;
      src_addr_i = '0;
      dst_addr_i = '0;
      count_i    = '0;
      cpu_reset  = 1'b0;

      // Reset and idle behaviour.
      repeat (3) @(posedge mem_clk);
      #1;
      checkIdleOutputs("inReset");
      checkOutput("errRst", error_o, 1'b0);
      cpu_reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge mem_clk);
         checkIdleOutputs("idle");
         checkOutput("errIdle", error_o, 1'b0);
      end

      // Preloaded four-word copy at latency 1.
      for (int i = 0; i < 4; i++) begin
         modelMem[32'h4000_0000 + 32'(i * 4)] = 32'hA0 + 32'(i);
         busMem[32'h4000_0000 + 32'(i * 4)]   = 32'hA0 + 32'(i);
      end
      runCase("plan4", 32'h4000_0000, 32'h4000_0100, 4, 1, -1, 0, 0);
      runCase("zero", 32'h1234_0000, 32'h2234_0000, 0, 1, -1, 0, 0);
      runCase("drop2", 32'h1100_0000, 32'h2100_0000, 4, 1, 1, 0, 0);
      runCase("clrErr", 32'h1180_0000, 32'h2180_0000, 1, 2, -1, 0, 0);
      runCase("badAck", 32'h1200_0000, 32'h2200_0000, 3, 1, -1, 1, 0);
      runCase("wrap", 32'hFFFF_FFF8, 32'h2300_0000, 4, 2, -1, 0, 1);

      for (int n = 0; n < 6; n++) begin
         src = 32'h1000_0000 | ($urandom & 32'h00FF_FFFC);
         dst = 32'h2800_0000 | ($urandom & 32'h00FF_FFFC);
         cnt = $urandom_range(1, 6);
         lat = $urandom_range(1, 4);
         runCase("rand", src, dst, cnt, lat, -1, 0, cnt >= 2);
      end

      // Reset during the first write wait with the ack arriving afterwards.
      curCase   = "midReset";
      rspLat    = 3;
      rspDropRd = -1;
      rspBadAck = 0;
      rdSeen    = 0;
      wrSeen    = 0;
      expQ.delete();
      e.isWrite = 0; e.addr = 32'h1300_0000; e.data = '0; e.user = refTag(0, 0);
      expQ.push_back(e);
      e.isWrite = 1; e.addr = 32'h2300_1000; e.data = modelWord(32'h1300_0000);
      e.user = refTag(1, 0);
      expQ.push_back(e);
      applyStimulus(32'h1300_0000, 32'h2300_1000, 16'd4, c);
      cnt = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge mem_clk);
         if (mem_m_write_o) begin
            cnt = 1;
            break;
         end
      end
      checkOutput("sawWrite", cnt, 1);
      @(posedge mem_clk);
      #1;
      cpu_reset = 1'b0;
      #1;
      checkIdleOutputs("rstMid");
      checkOutput("errRstMid", error_o, 1'b0);
      @(posedge mem_clk);
      #1;
      cpu_reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge mem_clk);
         checkIdleOutputs("lateRsp");
         checkOutput("errLate", error_o, 1'b0);
      end
      checkOutput("lateRspSent", pendQ.size(), 0);
      checkOutput("reqLeftRst", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
